// File: rtl/vxe_vpu_regu_qecu_pkg.sv
// Shared opcodes, register indices, error codes and opcode decode for the queued
// VPU register-update ECU.
package vxe_vpu_regu_qecu_pkg;

  localparam logic [4:0] CuCmdSetAcc = 5'h08;
  localparam logic [4:0] CuCmdSetVl  = 5'h09;
  localparam logic [4:0] CuCmdSetEn  = 5'h0A;
  localparam logic [4:0] CuCmdSetRs  = 5'h0B;
  localparam logic [4:0] CuCmdSetRt  = 5'h0C;
  localparam logic [4:0] CuCmdSetRd  = 5'h0D;

  localparam logic [2:0] VpuRegIdxIgn = 3'd0;
  localparam logic [2:0] VpuRegIdxAcc = 3'd1;
  localparam logic [2:0] VpuRegIdxVl  = 3'd2;
  localparam logic [2:0] VpuRegIdxEn  = 3'd3;
  localparam logic [2:0] VpuRegIdxRs  = 3'd4;
  localparam logic [2:0] VpuRegIdxRt  = 3'd5;
  localparam logic [2:0] VpuRegIdxRd  = 3'd6;

  localparam logic [1:0] VpuReguErrNone  = 2'b00;
  localparam logic [1:0] VpuReguErrIllOp = 2'b01;
  localparam logic [1:0] VpuReguErrBusy  = 2'b10;

  typedef enum logic [1:0] {StIdle, StWrite, StBcast, StSkip} head_st_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] ridx;
  } op_dec_t;

  function automatic op_dec_t decode_op(logic [4:0] op);
    op_dec_t d;
    d.vld = 1'b1;
    case (op)
      CuCmdSetAcc: d.ridx = VpuRegIdxAcc;
      CuCmdSetVl:  d.ridx = VpuRegIdxVl;
      CuCmdSetEn:  d.ridx = VpuRegIdxEn;
      CuCmdSetRs:  d.ridx = VpuRegIdxRs;
      CuCmdSetRt:  d.ridx = VpuRegIdxRt;
      CuCmdSetRd:  d.ridx = VpuRegIdxRd;
      default: begin
        d.vld  = 1'b0;
        d.ridx = VpuRegIdxIgn;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vxe_vpu_regu_fifo.sv
// Synchronous power-of-two FIFO with occupancy-derived full/empty flags.
module vxe_vpu_regu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_rdata = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= i_wdata;
  end

endmodule

// File: rtl/vxe_vpu_regu_qecu.sv
// Queued VPU register-update ECU: decodes commands into a FIFO and retires them
// through a shared, arbitrated register-file write port (with thread broadcast).
module vxe_vpu_regu_qecu
  import vxe_vpu_regu_qecu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NTHR       = 8,
  parameter int unsigned TH_W       = 3,
  parameter int unsigned DATA_W     = 38
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_disp,
  output logic              o_busy,
  output logic              o_done,
  input  logic [4:0]        i_cmd_op,
  input  logic [TH_W-1:0]   i_cmd_th,
  input  logic [47:0]       i_cmd_pl,
  output logic              o_wr_req,
  input  logic              i_wr_gnt,
  output logic [TH_W-1:0]   o_th,
  output logic [2:0]        o_ridx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  input  logic              i_err_clr
);

  localparam int unsigned EntW = 3 + TH_W + DATA_W + 2;

  op_dec_t           dec;
  logic [EntW-1:0]   ent_in, ent_head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [2:0]        h_ridx;
  logic [TH_W-1:0]   h_th;
  logic [DATA_W-1:0] h_data;
  logic              h_bcast, h_vld;
  head_st_e          st;
  logic [TH_W-1:0]   tc_q, tc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              ill, ovf;

  assign dec    = decode_op(i_cmd_op);
  assign ent_in = {dec.ridx, i_cmd_th, i_cmd_pl[DATA_W-1:0], i_cmd_pl[47], dec.vld};
  assign push   = i_disp & ~fifo_full;
  assign ovf    = i_disp & fifo_full;

  generate
    if (DATA_W < 47) begin : g_pl_unused
      logic unused_pl;
      assign unused_pl = ^i_cmd_pl[46:DATA_W];
    end
  endgenerate

  vxe_vpu_regu_fifo #(
    .WIDTH(EntW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nrst   (nrst),
    .i_push (push),
    .i_pop  (pop),
    .i_wdata(ent_in),
    .o_rdata(ent_head),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  assign {h_ridx, h_th, h_data, h_bcast, h_vld} = ent_head;

  // Head state is decoded straight from the queue head so a dispatch into an
  // empty queue raises o_wr_req on the very next cycle.
  always_comb begin
    st = StIdle;
    if (!fifo_empty) begin
      if (!h_vld)       st = StSkip;
      else if (h_bcast) st = StBcast;
      else              st = StWrite;
    end
  end

  always_comb begin
    o_wr_req = 1'b0;
    o_th     = '0;
    o_ridx   = VpuRegIdxIgn;
    o_data   = '0;
    pop      = 1'b0;
    done_d   = 1'b0;
    ill      = 1'b0;
    tc_d     = tc_q;
    unique case (st)
      StIdle: ;
      StSkip: begin
        pop    = 1'b1;
        done_d = 1'b1;
        ill    = 1'b1;
      end
      StWrite: begin
        o_wr_req = 1'b1;
        o_th     = h_th;
        o_ridx   = h_ridx;
        o_data   = h_data;
        pop      = i_wr_gnt;
        done_d   = i_wr_gnt;
      end
      StBcast: begin
        o_wr_req = 1'b1;
        o_th     = tc_q;
        o_ridx   = h_ridx;
        o_data   = h_data;
        if (i_wr_gnt) begin
          if (tc_q == TH_W'(NTHR - 1)) begin
            pop    = 1'b1;
            done_d = 1'b1;
            tc_d   = '0;
          end else begin
            tc_d = tc_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // A clear in the same cycle as a new error still records the new error.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (i_err_clr) begin
      err_d  = 1'b0;
      code_d = VpuReguErrNone;
    end
    if (ill || ovf) begin
      err_d = 1'b1;
      if (!err_q || i_err_clr) code_d = ill ? VpuReguErrIllOp : VpuReguErrBusy;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tc_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= VpuReguErrNone;
    end else begin
      tc_q   <= tc_d;
      done_q <= done_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign o_busy     = fifo_full;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_vxe_vpu_regu_qecu.sv
// Scoreboard bench for vxe_vpu_regu_qecu: stimulus queues expected writes, a
// negedge monitor checks every granted write and counts o_done pulses.
module tb_vxe_vpu_regu_qecu;

  localparam logic [4:0] OpAcc = 5'h08, OpVl = 5'h09, OpEn = 5'h0A;
  localparam logic [4:0] OpRs = 5'h0B, OpRt = 5'h0C, OpRd = 5'h0D;
  localparam logic [2:0] RIgn = 3'd0, RAcc = 3'd1, RVl = 3'd2, REn = 3'd3;
  localparam logic [2:0] RRs = 3'd4, RRt = 3'd5, RRd = 3'd6;

  typedef struct packed {
    logic [2:0]  th;
    logic [2:0]  ridx;
    logic [37:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_disp = 1'b0;
  logic        o_busy, o_done, o_wr_req, o_err;
  logic [4:0]  i_cmd_op = '0;
  logic [2:0]  i_cmd_th = '0;
  logic [47:0] i_cmd_pl = '0;
  logic        i_wr_gnt = 1'b0;
  logic [2:0]  o_th, o_ridx;
  logic [37:0] o_data;
  logic [1:0]  o_err_code;
  logic        i_err_clr = 1'b0;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_seen = 0;
  int  exp_done = 0;
  int  lastw_cyc = -1;
  int  done_cyc = -1;

  vxe_vpu_regu_qecu #(
    .FIFO_DEPTH(4),
    .NTHR      (8),
    .TH_W      (3),
    .DATA_W    (38)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_disp    (i_disp),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .i_cmd_op  (i_cmd_op),
    .i_cmd_th  (i_cmd_th),
    .i_cmd_pl  (i_cmd_pl),
    .o_wr_req  (o_wr_req),
    .i_wr_gnt  (i_wr_gnt),
    .o_th      (o_th),
    .o_ridx    (o_ridx),
    .o_data    (o_data),
    .o_err     (o_err),
    .o_err_code(o_err_code),
    .i_err_clr (i_err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nrst) begin
      if (o_wr_req && i_wr_gnt) begin
        wr_t got, want;
        got = '{th: o_th, ridx: o_ridx, data: o_data};
        lastw_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got=%h required=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL write got=%h required=%h", got, want);
          end
        end
      end
      if (o_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [2:0] th, input logic b,
                      input logic [37:0] d);
    i_disp   = 1'b1;
    i_cmd_op = op;
    i_cmd_th = th;
    i_cmd_pl = {b, 9'b0, d};
    tick();
    i_disp = 1'b0;
  endtask

  task automatic expw(input logic [2:0] th, input logic [2:0] r, input logic [37:0] d);
    exp_q.push_back('{th: th, ridx: r, data: d});
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_wr_req"}, 64'(o_wr_req), 64'd0);
    chk({tag, "_th"}, 64'(o_th), 64'd0);
    chk({tag, "_ridx"}, 64'(o_ridx), 64'(RIgn));
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_err"}, 64'(o_err), 64'd0);
    chk({tag, "_code"}, 64'(o_err_code), 64'd0);
  endtask

  initial begin
    logic [4:0] ops[4];
    logic [2:0] rix[4];
    ops = '{OpEn, OpRs, OpRt, OpRd};
    rix = '{REn, RRs, RRt, RRd};

    #2;
    chk_reset_outs("rst");
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // Single SETVL, grant tied high
    i_wr_gnt = 1'b1;
    expw(3'd2, RVl, 38'h15);
    disp(OpVl, 3'd2, 1'b0, 38'h15);
    chk("vl_req", 64'(o_wr_req), 64'd1);
    chk("vl_th", 64'(o_th), 64'd2);
    chk("vl_ridx", 64'(o_ridx), 64'(RVl));
    chk("vl_data", 64'(o_data), 64'h15);
    chk("vl_done_early", 64'(o_done), 64'd0);
    tick();
    chk("vl_done", 64'(o_done), 64'd1);
    chk("vl_req_off", 64'(o_wr_req), 64'd0);
    exp_done += 1;
    tick();
    chk("vl_done_cnt", 64'(done_seen), 64'(exp_done));

    // Fill the queue with grant low, then overflow
    i_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expw(3'(i), rix[i], 38'(32'h100 + i));
      disp(ops[i], 3'(i), 1'b0, 38'(32'h100 + i));
      if (i == 0) chk("q_busy_1", 64'(o_busy), 64'd0);
    end
    chk("q_busy_4", 64'(o_busy), 64'd1);
    chk("q_head_th", 64'(o_th), 64'd0);
    chk("q_head_ridx", 64'(o_ridx), 64'(REn));
    disp(OpRd, 3'd7, 1'b0, 38'hBAD);
    chk("ovf_err", 64'(o_err), 64'd1);
    chk("ovf_code", 64'(o_err_code), 64'd2);
    i_wr_gnt = 1'b1;
    tick();
    chk("q_busy_pop", 64'(o_busy), 64'd0);
    drain();
    tick();
    tick();
    exp_done += 4;
    chk("q_done_cnt", 64'(done_seen), 64'(exp_done));
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("clr_err", 64'(o_err), 64'd0);

    // Broadcast SETACC with toggling grant
    i_wr_gnt = 1'b0;
    for (int t = 0; t < 8; t++) expw(3'(t), RAcc, 38'h3FF);
    disp(OpAcc, 3'd5, 1'b1, 38'h3FF);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      i_wr_gnt = (c % 2 == 0);
      tick();
    end
    i_wr_gnt = 1'b0;
    chk("bc_drain", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    exp_done += 1;
    chk("bc_done_cnt", 64'(done_seen), 64'(exp_done));
    chk("bc_done_lat", 64'(done_cyc - lastw_cyc), 64'd1);

    // Illegal opcode followed by SETRS
    i_wr_gnt = 1'b1;
    expw(3'd1, RRs, 38'h22);
    disp(5'h1F, 3'd0, 1'b0, 38'h0);
    chk("ill_req", 64'(o_wr_req), 64'd0);
    chk("ill_done_early", 64'(o_done), 64'd0);
    disp(OpRs, 3'd1, 1'b0, 38'h22);
    chk("ill_done", 64'(o_done), 64'd1);
    chk("ill_err", 64'(o_err), 64'd1);
    chk("ill_code", 64'(o_err_code), 64'd1);
    chk("rs_ridx", 64'(o_ridx), 64'(RRs));
    tick();
    chk("rs_done", 64'(o_done), 64'd1);
    exp_done += 2;
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("ill_clr_err", 64'(o_err), 64'd0);
    chk("ill_clr_code", 64'(o_err_code), 64'd0);
    drain();
    chk("ill_done_cnt", 64'(done_seen), 64'(exp_done));

    // Reset in the middle of a broadcast with two entries queued
    for (int t = 0; t < 3; t++) expw(3'(t), RRd, 38'h77);
    disp(OpRd, 3'd5, 1'b1, 38'h77);
    disp(OpEn, 3'd1, 1'b0, 38'h1);
    disp(OpEn, 3'd2, 1'b0, 38'h2);
    tick();
    chk("mid_th", 64'(o_th), 64'd3);
    nrst = 1'b0;
    #1;
    chk_reset_outs("mid");
    tick();
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("post_req", 64'(o_wr_req), 64'd0);
    chk("post_exp", 64'(exp_q.size()), 64'd0);
    chk("post_done_cnt", 64'(done_seen), 64'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
